// File: rtl/conv_pkg.sv
// Shared types for the convolution frame sink: pixel type and sink FSM states.
package conv_pkg;
    localparam int DATA_W = 12;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        FLUSH
    } sink_state_t;
endpackage

// File: rtl/raster_counter.sv
// Raster (x,y) position counter over a W x H frame; wraps to (0,0) after the last pixel.
module raster_counter #(
    parameter int W = 4,
    parameter int H = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [$clog2(W)-1:0] x,
    output logic [$clog2(H)-1:0] y,
    output logic                 last_col,
    output logic                 last_pix
);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    assign last_col = (x == XW'(W - 1));
    assign last_pix = last_col && (y == YW'(H - 1));

    // clr together with inc means pixel 0 is consumed on this beat, so land on (1,0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= inc ? XW'(1) : '0;
            y <= '0;
        end else if (inc) begin
            if (last_col) begin
                x <= '0;
                y <= last_pix ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end
endmodule

// File: rtl/conv_frame_sink.sv
// Frame sink for the 3x3 convolution stream: strips window latency, zero-fills borders,
// emits exactly one full raster frame. Optional binarization under CONV_SINK_THRESH_EN.
module conv_frame_sink #(
    parameter int                ROW_LENGTH = 1280,
    parameter int                NUM_ROWS   = 960,
    parameter int                DATA_W     = conv_pkg::DATA_W,
    parameter logic [DATA_W-1:0] THRESH     = DATA_W'(128)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic                          i_sof,
    input  logic [DATA_W-1:0]             i_conv_data,
    output logic                          o_valid,
    output logic [DATA_W-1:0]             o_data,
    output logic [$clog2(ROW_LENGTH)-1:0] o_x,
    output logic [$clog2(NUM_ROWS)-1:0]   o_y,
    output logic                          o_sof,
    output logic                          o_eol,
    output logic                          o_eof,
    output logic                          o_overrun
);
    import conv_pkg::*;

    localparam int XW = $clog2(ROW_LENGTH);
    localparam int YW = $clog2(NUM_ROWS);

    sink_state_t state, state_nxt;

    logic [XW-1:0]     in_x, out_x;
    logic [YW-1:0]     in_y, out_y;
    logic              in_last_pix, unused_in_last_col;
    logic              out_last_col, out_last_pix;
    logic              in_inc, in_clr, out_clr;
    logic              emit, flush, overrun;
    logic              sof_beat, in_at_w, border;
    logic [DATA_W-1:0] pix_val;

    raster_counter #(.W(ROW_LENGTH), .H(NUM_ROWS)) u_in_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .inc      (in_inc),
        .clr      (in_clr),
        .x        (in_x),
        .y        (in_y),
        .last_col (unused_in_last_col),
        .last_pix (in_last_pix)
    );

    raster_counter #(.W(ROW_LENGTH), .H(NUM_ROWS)) u_out_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .inc      (emit),
        .clr      (out_clr),
        .x        (out_x),
        .y        (out_y),
        .last_col (out_last_col),
        .last_pix (out_last_pix)
    );

    assign sof_beat = i_valid && i_sof;
    assign in_at_w  = (in_y == YW'(1)) && (in_x == '0);
    assign border   = (out_x == '0) || out_last_col || (out_y == '0) || (out_y == YW'(NUM_ROWS - 1));

`ifdef CONV_SINK_THRESH_EN
    assign pix_val = (i_conv_data >= THRESH) ? {DATA_W{1'b1}} : '0;
`else
    logic unused_thresh;
    assign pix_val       = i_conv_data;
    assign unused_thresh = ^THRESH;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sof_beat) state_nxt = PRIME;
            PRIME:   if (sof_beat) state_nxt = PRIME;
                     else if (i_valid && in_at_w) state_nxt = STREAM;
            STREAM:  if (sof_beat) state_nxt = PRIME;
                     else if (i_valid && in_last_pix) state_nxt = FLUSH;
            FLUSH:   if (out_last_pix) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A sof beat anywhere but FLUSH restarts the frame with itself as pixel 0.
    always_comb begin
        in_inc  = 1'b0;
        in_clr  = 1'b0;
        out_clr = 1'b0;
        emit    = 1'b0;
        flush   = 1'b0;
        overrun = 1'b0;
        case (state)
            IDLE: begin
                if (sof_beat) begin
                    in_clr  = 1'b1;
                    in_inc  = 1'b1;
                    out_clr = 1'b1;
                end else if (i_valid) begin
                    overrun = 1'b1;
                end
            end
            PRIME, STREAM: begin
                if (sof_beat) begin
                    in_clr  = 1'b1;
                    in_inc  = 1'b1;
                    out_clr = 1'b1;
                end else if (i_valid) begin
                    in_inc = 1'b1;
                    emit   = (state == STREAM);
                end
            end
            FLUSH: begin
                emit    = 1'b1;
                flush   = 1'b1;
                overrun = i_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_x       <= '0;
            o_y       <= '0;
            o_sof     <= 1'b0;
            o_eol     <= 1'b0;
            o_eof     <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid   <= emit;
            o_overrun <= overrun;
            o_sof     <= emit && (out_x == '0) && (out_y == '0);
            o_eol     <= emit && out_last_col;
            o_eof     <= emit && out_last_pix;
            if (emit) begin
                o_data <= (border || flush) ? '0 : pix_val;
                o_x    <= out_x;
                o_y    <= out_y;
            end
        end
    end
endmodule
